sbox_byte_feeder: RTL

Upstream feeder for the forward S-box datapath.
- Accepts a full AES state block (NUM_BYTES bytes) over a valid/ready handshake.
- Serialises the block into one byte per cycle, driving the 8-bit U input of the forward top linear transform.
- Output is registered, so the combinational S-box path starts from a flop boundary.
- Provides byte index and first/last markers so downstream logic can reassemble the substituted block.

---
 rtl/sbox_byte_feeder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sbox_byte_feeder.sv
// Serialises a NUM_BYTES-byte AES state block into one registered byte per cycle for the S-box U input.
// Optional FEEDER_DOUBLE_BUF_EN adds a one-block holding register so consecutive blocks stream without a bubble.
module sbox_byte_feeder #(
    parameter int NUM_BYTES = 16,
    parameter int IDX_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_BYTES*8-1:0] in_block,
    output logic                   u_valid,
    input  logic                   u_ready,
    output logic [7:0]             u,
    output logic [IDX_W-1:0]       u_idx,
    output logic                   u_first,
    output logic                   u_last
);

    localparam int W = NUM_BYTES * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q;
    logic [W-1:0]     shift_q;
    logic [7:0]       u_q;
    logic [IDX_W-1:0] idx_q;
    logic             first_q;
    logic             last_q;
    logic             valid_q;

    logic             in_fire_s;
    logic             out_fire_s;
    logic             last_s;
    logic             load_s;
    logic [W-1:0]     load_blk_s;
    logic [IDX_W-1:0] idx_inc_s;

    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = valid_q && u_ready;
    assign last_s     = (idx_q == LAST_IDX);
    assign idx_inc_s  = idx_q + IDX_W'(1);

`ifdef FEEDER_DOUBLE_BUF_EN
    logic [W-1:0] hold_q;
    logic         hold_full_q;

    assign in_ready   = !hold_full_q;
    // A new block enters the shift register from IDLE, or at the last byte from the hold (or straight from the input).
    assign load_s     = ((state_q == IDLE) && in_fire_s) ||
                        ((state_q == SEND) && out_fire_s && last_s && (hold_full_q || in_fire_s));
    assign load_blk_s = hold_full_q ? hold_q : in_block;

    // Holding register: absorbs a block arriving mid-transmission, drains when it is promoted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q      <= {W{1'b0}};
            hold_full_q <= 1'b0;
        end else if (in_fire_s && !load_s) begin
            hold_q      <= in_block;
            hold_full_q <= 1'b1;
        end else if (load_s && hold_full_q) begin
            hold_full_q <= 1'b0;
        end
    end
`else
    assign in_ready   = (state_q == IDLE);
    assign load_s     = (state_q == IDLE) && in_fire_s;
    assign load_blk_s = in_block;
`endif

    // Feeder FSM with the registered byte, index and markers; shift_q holds the bytes still to follow u.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= {W{1'b0}};
            u_q     <= 8'h00;
            idx_q   <= {IDX_W{1'b0}};
            first_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_s) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                SEND: begin
                    if (out_fire_s && last_s && !load_s) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase

            if (load_s) begin
                u_q     <= load_blk_s[W-1 -: 8];
                shift_q <= {load_blk_s[W-9:0], 8'h00};
                idx_q   <= {IDX_W{1'b0}};
                first_q <= 1'b1;
                last_q  <= 1'b0;
            end else if (out_fire_s && last_s) begin
                u_q     <= 8'h00;
                idx_q   <= {IDX_W{1'b0}};
                first_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (out_fire_s) begin
                u_q     <= shift_q[W-1 -: 8];
                shift_q <= {shift_q[W-9:0], 8'h00};
                idx_q   <= idx_inc_s;
                first_q <= 1'b0;
                last_q  <= (idx_inc_s == LAST_IDX);
            end
        end
    end

    assign u_valid = valid_q;
    assign u       = u_q;
    assign u_idx   = idx_q;
    assign u_first = first_q;
    assign u_last  = last_q;

endmodule
